// File: rtl/tick_divider_pkg.sv
// Shared constants and types for the multi-channel tick divider.
package tick_divider_pkg;

  localparam int unsigned CLK_HZ        = 100_000_000;
  localparam int unsigned CNT_W_DEFAULT = 28;
  localparam int unsigned DIV_2HZ       = 50_000_000;
  localparam int unsigned DIV_1KHZ      = 100_000;

  typedef enum logic [0:0] {
    UPD_IDLE    = 1'b0,
    UPD_PENDING = 1'b1
  } upd_state_t;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_divider_ch.sv
// One divider channel: counter, programmable divisor, tick and square outputs.
module tick_divider_ch
  import tick_divider_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = DIV_2HZ
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             load_ok,
  output logic             tick,
  output logic             clk_out
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic             active;
  logic             wrap;

  assign active  = en && (div != '0);
  assign wrap    = active && (cnt == div - CNT_W'(1));
  // A new divisor may only land on a wrap edge, or anywhere while the channel is idle.
  assign load_ok = wrap || !active;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      div     <= CNT_W'(DEFAULT_DIV);
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else if (sync) begin
      cnt     <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      tick <= wrap;
      if (wrap) clk_out <= ~clk_out;
      if (load) div <= load_val;
      if (wrap || !active || load) cnt <= '0;
      else                         cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tick_divider.sv
// NUM_CH-channel clock-enable generator with a single shared divisor-update slot.
// Define TICK_DIVIDER_SYNC_EN to add the sync input that phase-aligns all channels.
module tick_divider
  import tick_divider_pkg::*;
#(
  parameter  int unsigned NUM_CH      = 4,
  parameter  int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter  int unsigned DEFAULT_DIV = DIV_2HZ,
  localparam int unsigned CH_W        = ch_width(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] enable,
  input  logic              div_valid,
  output logic              div_ready,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
`ifdef TICK_DIVIDER_SYNC_EN
  ,
  input  logic              sync
`endif
);

  localparam logic [CH_W:0] NUM_CH_EXT = (CH_W+1)'(NUM_CH);

  logic              sync_i;
  upd_state_t        state;
  logic [CH_W-1:0]   pend_ch;
  logic [CNT_W-1:0]  pend_val;
  logic [NUM_CH-1:0] load_ok;
  logic [NUM_CH-1:0] load;
  logic              ch_in_range;

`ifdef TICK_DIVIDER_SYNC_EN
  assign sync_i = sync;
`else
  assign sync_i = 1'b0;
`endif

  assign div_ready   = (state == UPD_IDLE);
  assign ch_in_range = ({1'b0, div_ch} < NUM_CH_EXT);

  // Requests for non-existent channels are accepted but never leave IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= UPD_IDLE;
      pend_ch  <= '0;
      pend_val <= '0;
    end else begin
      case (state)
        UPD_IDLE: begin
          if (div_valid && ch_in_range) begin
            state    <= UPD_PENDING;
            pend_ch  <= div_ch;
            pend_val <= div_val;
          end
        end
        UPD_PENDING: begin
          if (|load) state <= UPD_IDLE;
        end
        default: state <= UPD_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // sync wins over a pending apply, which simply waits for a later edge.
    assign load[i] = (state == UPD_PENDING) && (pend_ch == CH_W'(i)) &&
                     load_ok[i] && !sync_i;

    tick_divider_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clock    (clock),
      .reset_n  (reset_n),
      .en       (enable[i]),
      .sync     (sync_i),
      .load     (load[i]),
      .load_val (pend_val),
      .load_ok  (load_ok[i]),
      .tick     (tick[i]),
      .clk_out  (clk_out[i])
    );
  end

endmodule
